// File: rtl/l2_noc2_arb_pkg.sv
// Shared types and constants for the L2 NoC2 output-port arbiter.
package l2_noc2_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    localparam logic REQ_PIPE1 = 1'b0;
    localparam logic REQ_PIPE2 = 1'b1;

    localparam logic [1:0] FLIT_HDR = 2'd0;
    localparam logic [1:0] FLIT_D0  = 2'd1;
    localparam logic [1:0] FLIT_D1  = 2'd2;

    // Width needed to hold 0..limit inclusive.
    function automatic int starve_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/l2_noc2_arb_if.sv
// Message request ports of both pipes plus the NoC2 flit output port.
interface l2_noc2_arb_if #(
    parameter int FLIT_W = 64
) ();
    logic              p1_req_valid;
    logic              p1_req_ready;
    logic [FLIT_W-1:0] p1_req_header;
    logic [FLIT_W-1:0] p1_req_data0;
    logic [FLIT_W-1:0] p1_req_data1;
    logic [1:0]        p1_req_len;
    logic              p2_req_valid;
    logic              p2_req_ready;
    logic [FLIT_W-1:0] p2_req_header;
    logic [FLIT_W-1:0] p2_req_data0;
    logic [FLIT_W-1:0] p2_req_data1;
    logic [1:0]        p2_req_len;
    logic              noc2_valid_out;
    logic              noc2_ready_out;
    logic [FLIT_W-1:0] noc2_data_out;

    // Arbiter side.
    modport slave (
        input  p1_req_valid, p1_req_header, p1_req_data0, p1_req_data1, p1_req_len,
        input  p2_req_valid, p2_req_header, p2_req_data0, p2_req_data1, p2_req_len,
        input  noc2_ready_out,
        output p1_req_ready, p2_req_ready, noc2_valid_out, noc2_data_out
    );

    // Pipe encoders and NoC2 buffer side.
    modport master (
        output p1_req_valid, p1_req_header, p1_req_data0, p1_req_data1, p1_req_len,
        output p2_req_valid, p2_req_header, p2_req_data0, p2_req_data1, p2_req_len,
        output noc2_ready_out,
        input  p1_req_ready, p2_req_ready, noc2_valid_out, noc2_data_out
    );
endinterface

// File: rtl/l2_noc2_arb_pick.sv
// Winner select between pipe1 and pipe2 with starvation counter and last-grant state.
module l2_noc2_arb_pick
    import l2_noc2_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter bit PIPE2_PRIO   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic p1_valid,
    input  logic p2_valid,
    output logic p1_ready,
    output logic p2_ready,
    output logic win_id
);
    localparam int            SW    = starve_cnt_w(STARVE_LIMIT);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          last_grant;
    logic          accept;

    always_comb begin
        win_id = REQ_PIPE1;
        if (p1_valid && p2_valid) begin
            if (PIPE2_PRIO)
                win_id = (starve_cnt == LIMIT) ? REQ_PIPE1 : REQ_PIPE2;
            else
                win_id = (last_grant == REQ_PIPE2) ? REQ_PIPE1 : REQ_PIPE2;
        end else if (p2_valid) begin
            win_id = REQ_PIPE2;
        end
    end

    assign p1_ready = enable && p1_valid && (win_id == REQ_PIPE1);
    assign p2_ready = enable && p2_valid && (win_id == REQ_PIPE2);
    assign accept   = p1_ready || p2_ready;

    // Starvation only counts contested wins by pipe2; any pipe1 grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            last_grant <= REQ_PIPE2;
        end else if (accept) begin
            last_grant <= win_id;
            if (!PIPE2_PRIO || win_id == REQ_PIPE1)
                starve_cnt <= '0;
            else if (p1_valid && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule

// File: rtl/l2_noc2_arb.sv
// L2 NoC2 output arbiter: accepts one whole message from a pipe and serializes it onto NoC2.
module l2_noc2_arb
    import l2_noc2_arb_pkg::*;
#(
    parameter int FLIT_W       = 64,
    parameter int MAX_PAYLOAD  = 2,
    parameter int STARVE_LIMIT = 4,
    parameter bit PIPE2_PRIO   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    l2_noc2_arb_if.slave       bus,
    output logic               arb_busy,
    output logic               arb_grant_id
);
    localparam logic [1:0] LEN_CAP = 2'(MAX_PAYLOAD);

    arb_state_e        state, state_nxt;
    logic [FLIT_W-1:0] hdr_q, d0_q, d1_q, data_q;
    logic [1:0]        len_q, idx_q;
    logic              grant_q, valid_q;
    logic              win_id, accept, flit_done, last_flit;

    function automatic logic [1:0] clamp_len(input logic [1:0] len);
        return (len > LEN_CAP) ? LEN_CAP : len;
    endfunction

    // Readies are gated by rst_n so nothing is offered while reset is held.
    l2_noc2_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .PIPE2_PRIO   (PIPE2_PRIO)
    ) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   ((state == IDLE) && rst_n),
        .p1_valid (bus.p1_req_valid),
        .p2_valid (bus.p2_req_valid),
        .p1_ready (bus.p1_req_ready),
        .p2_ready (bus.p2_req_ready),
        .win_id   (win_id)
    );

    assign accept    = bus.p1_req_ready || bus.p2_req_ready;
    assign flit_done = valid_q && bus.noc2_ready_out;
    assign last_flit = flit_done && (idx_q == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = SEND;
            SEND:    if (last_flit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            data_q  <= '0;
            len_q   <= '0;
            idx_q   <= FLIT_HDR;
            grant_q <= REQ_PIPE1;
            valid_q <= 1'b0;
        end else if (state == IDLE && accept) begin
            hdr_q   <= (win_id == REQ_PIPE2) ? bus.p2_req_header : bus.p1_req_header;
            d0_q    <= (win_id == REQ_PIPE2) ? bus.p2_req_data0  : bus.p1_req_data0;
            d1_q    <= (win_id == REQ_PIPE2) ? bus.p2_req_data1  : bus.p1_req_data1;
            len_q   <= clamp_len((win_id == REQ_PIPE2) ? bus.p2_req_len : bus.p1_req_len);
            data_q  <= (win_id == REQ_PIPE2) ? bus.p2_req_header : bus.p1_req_header;
            idx_q   <= FLIT_HDR;
            grant_q <= win_id;
            valid_q <= 1'b1;
        end else if (state == SEND && flit_done) begin
            if (last_flit) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                idx_q  <= idx_q + 2'd1;
                data_q <= (idx_q == FLIT_HDR) ? d0_q : d1_q;
            end
        end
    end

    assign bus.noc2_valid_out = valid_q;
    assign bus.noc2_data_out  = data_q;
    assign arb_busy           = (state == SEND);
    assign arb_grant_id       = grant_q;
endmodule

// File: tb/tb_l2_noc2_arb.sv
// Directed bench for l2_noc2_arb: priority/starvation instance and round-robin instance.
module tb_l2_noc2_arb;
    logic clk = 1'b0;
    logic rst_n;
    logic busy_a, gid_a, busy_b, gid_b;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_s_a[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    logic [63:0] clamp_exp[3] = '{64'h21, 64'h22, 64'h23};

    always #5 clk = ~clk;

    l2_noc2_arb_if #(.FLIT_W(64)) bus_a ();
    l2_noc2_arb_if #(.FLIT_W(64)) bus_b ();

    l2_noc2_arb #(.FLIT_W(64), .MAX_PAYLOAD(2), .STARVE_LIMIT(4), .PIPE2_PRIO(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .arb_busy(busy_a), .arb_grant_id(gid_a));
    l2_noc2_arb #(.FLIT_W(64), .MAX_PAYLOAD(2), .STARVE_LIMIT(4), .PIPE2_PRIO(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .arb_busy(busy_b), .arb_grant_id(gid_b));

    // A pending request must be held until it is accepted.
    a_p1_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
        (bus_a.p1_req_valid && !bus_a.p1_req_ready) |=> bus_a.p1_req_valid);
    a_p2_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
        (bus_a.p2_req_valid && !bus_a.p2_req_ready) |=> bus_a.p2_req_valid);
    a_p1_hold_b: assert property (@(posedge clk) disable iff (!rst_n)
        (bus_b.p1_req_valid && !bus_b.p1_req_ready) |=> bus_b.p1_req_valid);
    a_p2_hold_b: assert property (@(posedge clk) disable iff (!rst_n)
        (bus_b.p2_req_valid && !bus_b.p2_req_ready) |=> bus_b.p2_req_valid);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy1(input bit sel);
        return sel ? bus_b.p1_req_ready : bus_a.p1_req_ready;
    endfunction
    function automatic logic rdy2(input bit sel);
        return sel ? bus_b.p2_req_ready : bus_a.p2_req_ready;
    endfunction
    function automatic logic vld_any(input bit sel);
        return sel ? (bus_b.p1_req_valid || bus_b.p2_req_valid)
                   : (bus_a.p1_req_valid || bus_a.p2_req_valid);
    endfunction

    task automatic set_req_a(input bit pipe, input logic [63:0] h, input logic [63:0] d0,
                             input logic [63:0] d1, input logic [1:0] len);
        if (pipe) begin
            bus_a.p2_req_header = h; bus_a.p2_req_data0 = d0;
            bus_a.p2_req_data1 = d1; bus_a.p2_req_len = len; bus_a.p2_req_valid = 1'b1;
        end else begin
            bus_a.p1_req_header = h; bus_a.p1_req_data0 = d0;
            bus_a.p1_req_data1 = d1; bus_a.p1_req_len = len; bus_a.p1_req_valid = 1'b1;
        end
    endtask

    task automatic run_grants(input bit sel, input int n, input logic [9:0] exp_g);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            while (!(rdy1(sel) || rdy2(sel)) && t < 20) begin
                tick;
                t++;
            end
            chk($sformatf("grant_wait%0d", k), 64'(t < 20), 64'd1);
            chk($sformatf("grant_onehot%0d", k), 64'(rdy1(sel) && rdy2(sel)), 64'd0);
            chk($sformatf("grant%0d", k), 64'(rdy2(sel)), 64'(exp_g[k]));
            tick;
            chk($sformatf("grant_id%0d", k), 64'(sel ? gid_b : gid_a), 64'(exp_g[k]));
            chk($sformatf("starve%0d", k),
                64'(sel ? u_b.u_pick.starve_cnt : u_a.u_pick.starve_cnt),
                64'(sel ? 0 : exp_s_a[k]));
        end
    endtask

    task automatic drain(input bit sel);
        for (int t = 0; t < 20 && vld_any(sel); t++) begin
            logic a, b;
            a = rdy1(sel);
            b = rdy2(sel);
            tick;
            if (a) begin if (sel) bus_b.p1_req_valid = 1'b0; else bus_a.p1_req_valid = 1'b0; end
            if (b) begin if (sel) bus_b.p2_req_valid = 1'b0; else bus_a.p2_req_valid = 1'b0; end
        end
        chk("drain", 64'(vld_any(sel)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        bus_a.p1_req_valid = 0; bus_a.p1_req_header = 0; bus_a.p1_req_data0 = 0;
        bus_a.p1_req_data1 = 0; bus_a.p1_req_len = 0;
        bus_a.p2_req_valid = 0; bus_a.p2_req_header = 0; bus_a.p2_req_data0 = 0;
        bus_a.p2_req_data1 = 0; bus_a.p2_req_len = 0; bus_a.noc2_ready_out = 1;
        bus_b.p1_req_valid = 0; bus_b.p1_req_header = 64'h11; bus_b.p1_req_data0 = 0;
        bus_b.p1_req_data1 = 0; bus_b.p1_req_len = 0;
        bus_b.p2_req_valid = 0; bus_b.p2_req_header = 64'h22; bus_b.p2_req_data0 = 0;
        bus_b.p2_req_data1 = 0; bus_b.p2_req_len = 0; bus_b.noc2_ready_out = 1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus_a.noc2_valid_out), 64'd0);
        chk("rst_data", bus_a.noc2_data_out, 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_gid", 64'(gid_a), 64'd0);
        chk("rst_starve", 64'(u_a.u_pick.starve_cnt), 64'd0);
        chk("rst_last_grant", 64'(u_a.u_pick.last_grant), 64'd1);
        bus_a.p1_req_valid = 1'b1;
        #1;
        chk("rst_p1_ready", 64'(bus_a.p1_req_ready), 64'd0);
        bus_a.p1_req_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;

        // Single p1 message, len 2.
        set_req_a(1'b0, 64'hA1, 64'hB1, 64'hC1, 2'd2);
        #1;
        chk("t1_p1_ready", 64'(bus_a.p1_req_ready), 64'd1);
        chk("t1_p2_ready", 64'(bus_a.p2_req_ready), 64'd0);
        chk("t1_valid_c0", 64'(bus_a.noc2_valid_out), 64'd0);
        tick;
        bus_a.p1_req_valid = 1'b0;
        chk("t1_valid_c1", 64'(bus_a.noc2_valid_out), 64'd1);
        chk("t1_hdr", bus_a.noc2_data_out, 64'hA1);
        chk("t1_busy", 64'(busy_a), 64'd1);
        chk("t1_gid", 64'(gid_a), 64'd0);
        chk("t1_p1_ready_send", 64'(bus_a.p1_req_ready), 64'd0);
        tick;
        chk("t1_d0", bus_a.noc2_data_out, 64'hB1);
        tick;
        chk("t1_d1", bus_a.noc2_data_out, 64'hC1);
        tick;
        chk("t1_valid_c4", 64'(bus_a.noc2_valid_out), 64'd0);
        chk("t1_busy_c4", 64'(busy_a), 64'd0);

        // Backpressure: header held while noc2 is not ready, p2 waits.
        set_req_a(1'b0, 64'hA1, 64'h0, 64'h0, 2'd0);
        bus_a.noc2_ready_out = 1'b0;
        tick;
        bus_a.p1_req_valid = 1'b0;
        set_req_a(1'b1, 64'h2A, 64'h0, 64'h0, 2'd0);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_data%0d", i), bus_a.noc2_data_out, 64'hA1);
            chk($sformatf("hold_valid%0d", i), 64'(bus_a.noc2_valid_out), 64'd1);
            chk($sformatf("hold_p2_ready%0d", i), 64'(bus_a.p2_req_ready), 64'd0);
            if (i < 4) tick;
        end
        bus_a.noc2_ready_out = 1'b1;
        tick;
        chk("hold_idle_valid", 64'(bus_a.noc2_valid_out), 64'd0);
        chk("hold_p2_ready_idle", 64'(bus_a.p2_req_ready), 64'd1);
        tick;
        bus_a.p2_req_valid = 1'b0;
        chk("hold_p2_hdr", bus_a.noc2_data_out, 64'h2A);
        chk("hold_p2_gid", 64'(gid_a), 64'd1);
        tick;

        // len=3 from p2 clamps to two payload flits.
        set_req_a(1'b1, 64'h21, 64'h22, 64'h23, 2'd3);
        #1;
        chk("clamp_p2_ready", 64'(bus_a.p2_req_ready), 64'd1);
        tick;
        bus_a.p2_req_valid = 1'b0;
        cnt = 0;
        for (int t = 0; t < 6; t++) begin
            if (bus_a.noc2_valid_out && bus_a.noc2_ready_out) begin
                if (cnt < 3) chk($sformatf("clamp_flit%0d", cnt), bus_a.noc2_data_out, clamp_exp[cnt]);
                cnt++;
            end
            tick;
        end
        chk("clamp_count", 64'(cnt), 64'd3);

        // Contested stream with pipe2 priority and starvation guard.
        set_req_a(1'b0, 64'h11, 64'h0, 64'h0, 2'd0);
        set_req_a(1'b1, 64'h22, 64'h0, 64'h0, 2'd0);
        #1;
        run_grants(1'b0, 10, 10'b0111101111);
        drain(1'b0);

        // Round-robin instance alternates starting with pipe1.
        bus_b.p1_req_valid = 1'b1;
        bus_b.p2_req_valid = 1'b1;
        #1;
        run_grants(1'b1, 4, 10'b0000001010);
        drain(1'b1);
        repeat (3) tick;

        // Reset asserted while payload flit 0 is on the wire.
        set_req_a(1'b1, 64'h61, 64'h62, 64'h63, 2'd2);
        tick;
        bus_a.p2_req_valid = 1'b0;
        chk("mid_hdr", bus_a.noc2_data_out, 64'h61);
        tick;
        chk("mid_d0", bus_a.noc2_data_out, 64'h62);
        chk("mid_gid", 64'(gid_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus_a.noc2_valid_out), 64'd0);
        chk("mid_rst_data", bus_a.noc2_data_out, 64'd0);
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_gid", 64'(gid_a), 64'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        set_req_a(1'b0, 64'h71, 64'h0, 64'h0, 2'd0);
        #1;
        chk("post_p1_ready", 64'(bus_a.p1_req_ready), 64'd1);
        tick;
        bus_a.p1_req_valid = 1'b0;
        chk("post_valid", 64'(bus_a.noc2_valid_out), 64'd1);
        chk("post_hdr", bus_a.noc2_data_out, 64'h71);
        chk("post_gid", 64'(gid_a), 64'd0);
        tick;
        chk("post_done", 64'(bus_a.noc2_valid_out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
